// File: rtl/bin2bcd_conv_if.sv
// Bus bundle between the bridge and the binary-to-BCD converter, plus the
// converter's outgoing digit-write channel toward the display stage.
interface bin2bcd_conv_if;
  logic [31:0] addr_from_bg;
  logic        we_from_bg;
  logic [31:0] wdata_from_bg;
  logic [31:0] rdata_2_bg;
  logic [31:0] bcd_data_2_dig;
  logic        bcd_we_2_dig;
  logic        busy_2_bg;

  // Bridge / bench side: drives the bus, observes everything the converter produces.
  modport master (
    output addr_from_bg, we_from_bg, wdata_from_bg,
    input  rdata_2_bg, bcd_data_2_dig, bcd_we_2_dig, busy_2_bg
  );

  // Converter side.
  modport slave (
    input  addr_from_bg, we_from_bg, wdata_from_bg,
    output rdata_2_bg, bcd_data_2_dig, bcd_we_2_dig, busy_2_bg
  );
endinterface

// File: rtl/bin2bcd_conv.sv
// Memory-mapped binary-to-BCD converter. A write to the value register runs a
// 27-step double-dabble conversion; the eight packed BCD digits are then handed
// to the display stage with a one-cycle strobe. Values above 99,999,999 do not
// fit eight digits and are shown as all 'E' digits instead.
module bin2bcd_conv #(
  parameter logic [31:0] ADDR_DATA = 32'hFFFF_F000,
  parameter logic [31:0] ADDR_STAT = 32'hFFFF_F004
) (
  input  logic              clk_from_bg,
  input  logic              rst_from_bg,
  bin2bcd_conv_if.slave     bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CONV = 2'd1,
    DONE = 2'd2
  } state_e;

  localparam logic [31:0] MAX_DISPLAYABLE = 32'd99_999_999;
  localparam logic [31:0] OVERFLOW_CODE   = 32'hEEEE_EEEE;
  localparam logic [4:0]  NUM_ITER        = 5'd27;

  state_e      state_q, state_d;
  logic [4:0]  cnt_q, cnt_d;
  logic [31:0] acc_q, acc_d;
  logic [26:0] bin_q, bin_d;
  logic        ovf_q, ovf_d;
  logic        ovr_q, ovr_d;
  logic [31:0] bcd_q, bcd_d;
  logic        bcd_we_q, bcd_we_d;

  logic        data_wr_s;
  logic        stat_wr_s;
  logic [31:0] adj_s;
  logic [31:0] acc_shift_s;

  // Double-dabble correction: any digit of 5 or more gets +3 so that the
  // following left shift carries correctly into the next decimal digit.
  function automatic logic [31:0] dd_adjust(input logic [31:0] acc);
    logic [31:0] res;
    logic [3:0]  digit;
    res = acc;
    for (int i = 0; i < 8; i++) begin
      digit = acc[4*i +: 4];
      if (digit >= 4'd5) begin
        res[4*i +: 4] = digit + 4'd3;
      end else begin
        res[4*i +: 4] = digit;
      end
    end
    return res;
  endfunction

  assign data_wr_s   = bus.we_from_bg && (bus.addr_from_bg == ADDR_DATA);
  assign stat_wr_s   = bus.we_from_bg && (bus.addr_from_bg == ADDR_STAT);
  assign adj_s       = dd_adjust(acc_q);
  assign acc_shift_s = {adj_s[30:0], bin_q[26]};

  // Next-state, datapath and flag update for the conversion FSM.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    bin_d    = bin_q;
    ovf_d    = ovf_q;
    bcd_d    = bcd_q;
    bcd_we_d = 1'b0;
    // A status write clears overrun; a dropped data write below overrides it.
    if (stat_wr_s) begin
      ovr_d = 1'b0;
    end else begin
      ovr_d = ovr_q;
    end
    case (state_q)
      IDLE: begin
        if (data_wr_s) begin
          bin_d   = bus.wdata_from_bg[26:0];
          acc_d   = 32'h0;
          cnt_d   = NUM_ITER;
          ovf_d   = (bus.wdata_from_bg > MAX_DISPLAYABLE);
          state_d = CONV;
        end else begin
          state_d = IDLE;
        end
      end
      CONV: begin
        if (data_wr_s) begin
          ovr_d = 1'b1;
        end else begin
          ovr_d = ovr_d;
        end
        acc_d = acc_shift_s;
        bin_d = {bin_q[25:0], 1'b0};
        cnt_d = cnt_q - 5'd1;
        // Last iteration: publish the finished digits on the same edge.
        if (cnt_q == 5'd1) begin
          state_d  = DONE;
          bcd_we_d = 1'b1;
          bcd_d    = ovf_q ? OVERFLOW_CODE : acc_shift_s;
        end else begin
          state_d  = CONV;
        end
      end
      DONE: begin
        if (data_wr_s) begin
          ovr_d = 1'b1;
        end else begin
          ovr_d = ovr_d;
        end
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers; reset wins over any same-cycle write.
  always_ff @(posedge clk_from_bg) begin
    if (rst_from_bg) begin
      state_q  <= IDLE;
      cnt_q    <= 5'd0;
      acc_q    <= 32'h0;
      bin_q    <= 27'h0;
      ovf_q    <= 1'b0;
      ovr_q    <= 1'b0;
      bcd_q    <= 32'h0;
      bcd_we_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      bin_q    <= bin_d;
      ovf_q    <= ovf_d;
      ovr_q    <= ovr_d;
      bcd_q    <= bcd_d;
      bcd_we_q <= bcd_we_d;
    end
  end

  // Combinational register read-back toward the bridge.
  always_comb begin
    if (bus.addr_from_bg == ADDR_STAT) begin
      bus.rdata_2_bg = {29'b0, ovf_q, ovr_q, (state_q != IDLE)};
    end else if (bus.addr_from_bg == ADDR_DATA) begin
      bus.rdata_2_bg = bcd_q;
    end else begin
      bus.rdata_2_bg = 32'h0;
    end
  end

  assign bus.bcd_data_2_dig = bcd_q;
  assign bus.bcd_we_2_dig   = bcd_we_q;
  assign bus.busy_2_bg      = (state_q != IDLE);

endmodule
